// File: rtl/karatsuba_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : karatsuba_pkg
//  Description : Shared FSM state encoding and latency helper for the
//                sequential Karatsuba multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package karatsuba_pkg;

   // Controller states: capture, split, multiply, recombine, apply sign
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_MUL     = 3'd2,
      ST_COMBINE = 3'd3,
      ST_SIGN    = 3'd4
   } state_t;

   // Cycles from the start-sampling edge to the edge that raises done
   function automatic int mul_latency(input int width);
      return width / 2 + 4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/karatsuba_mul_seq_shift_add_mul_u.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul_u
//  Description : Unsigned N x N -> 2N-bit shift-add multiplier. The operands
//                are loaded on the start edge and N iterations follow, one
//                per clock. o_done is high in the cycle before the final
//                iteration edge, so o_prod is complete right after the edge
//                that samples o_done. o_prod holds until the next start.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul_u #(
   parameter int N = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_start,
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic           o_done,
   output logic [2*N-1:0] o_prod
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0]  r_cnt;
   logic           r_active;
   logic [N-1:0]   r_mcand;
   logic [2*N-1:0] r_acc;     // {partial sum, remaining multiplier bits}
   logic [N:0]     w_sum;

   // Add the multiplicand into the upper half when the current bit is set
   assign w_sum = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_mcand} : {(N+1){1'b0}});

   // Load operands on start, then shift right one multiplier bit per cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_start) begin
         r_acc    <= {{N{1'b0}}, i_b};
         r_mcand  <= i_a;
         r_cnt    <= CW'(N);
         r_active <= 1'b1;
      end else if (r_active) begin
         r_acc <= {w_sum, r_acc[N-1:1]};
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CW'(1)) begin
            r_active <= 1'b0;
         end
      end
   end

   assign o_done = r_active && (r_cnt == CW'(1));
   assign o_prod = r_acc;

endmodule
`default_nettype wire

// File: rtl/karatsuba_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : karatsuba_mul_seq
//  Description : Sequential Karatsuba multiplier for the MUL instruction.
//                Operand magnitudes are split into halves and three unsigned
//                shift-add multipliers run in parallel; the full product is
//                recombined, signed if required, and overflow against WIDTH
//                bits is flagged. busy/done handshake toward control.
//  Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_mul_seq
   import karatsuba_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic               i_signed_mode,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product,
   output logic               o_overflow
);

   localparam int HALF = WIDTH / 2;
   localparam int N    = HALF + 1;     // sub-multiplier width (sum carry kept)
   localparam int PW   = 2 * WIDTH;
   localparam int ZW   = 2 * N;

   state_t            r_state, w_next;
   logic              w_sub_start;
   logic [WIDTH-1:0]  r_amag, r_bmag;
   logic              r_neg, r_signed;
   logic [PW-1:0]     r_mag, r_product;
   logic              r_overflow, r_done;

   logic [WIDTH-1:0]  w_a_mag, w_b_mag;
   logic [HALF-1:0]   w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   logic [HALF:0]     w_a_s, w_b_s;
   logic [ZW-1:0]     w_z0, w_z2, w_zs;
   logic              w_done0, w_done2, w_dones;
   logic              w_sub_done;
   logic [PW-1:0]     w_z0_x, w_z2_x, w_zs_x, w_z1, w_mag, w_prod;
   logic              w_ovf;

   // Signed magnitudes: the most negative value maps to 2^(WIDTH-1), still unsigned-representable
   assign w_a_mag = (i_signed_mode && i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
   assign w_b_mag = (i_signed_mode && i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;

   assign w_a_lo = r_amag[HALF-1:0];
   assign w_a_hi = r_amag[WIDTH-1:HALF];
   assign w_b_lo = r_bmag[HALF-1:0];
   assign w_b_hi = r_bmag[WIDTH-1:HALF];
   assign w_a_s  = {1'b0, w_a_lo} + {1'b0, w_a_hi};
   assign w_b_s  = {1'b0, w_b_lo} + {1'b0, w_b_hi};

   shift_add_mul_u #(.N(N)) u_mul_z0 (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_sub_start),
      .i_a     ({1'b0, w_a_lo}),
      .i_b     ({1'b0, w_b_lo}),
      .o_done  (w_done0),
      .o_prod  (w_z0)
   );

   shift_add_mul_u #(.N(N)) u_mul_z2 (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_sub_start),
      .i_a     ({1'b0, w_a_hi}),
      .i_b     ({1'b0, w_b_hi}),
      .o_done  (w_done2),
      .o_prod  (w_z2)
   );

   shift_add_mul_u #(.N(N)) u_mul_zs (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_sub_start),
      .i_a     (w_a_s),
      .i_b     (w_b_s),
      .o_done  (w_dones),
      .o_prod  (w_zs)
   );

   // All three run in lockstep; require agreement before recombining
   assign w_sub_done = w_done0 & w_done2 & w_dones;

   // Recombination at full product width so the middle term never truncates
   assign w_z0_x = PW'(w_z0);
   assign w_z2_x = PW'(w_z2);
   assign w_zs_x = PW'(w_zs);
   assign w_z1   = w_zs_x - w_z0_x - w_z2_x;
   assign w_mag  = (w_z2_x << WIDTH) + (w_z1 << HALF) + w_z0_x;

   assign w_prod = r_neg ? (~r_mag + 1'b1) : r_mag;
   assign w_ovf  = r_signed ? !((&w_prod[PW-1:WIDTH-1]) || !(|w_prod[PW-1:WIDTH-1]))
                            : (|w_prod[PW-1:WIDTH]);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and sub-multiplier start strobe
   always_comb begin
      w_next      = r_state;
      w_sub_start = 1'b0;
      case (r_state)
         ST_IDLE:    if (i_start) w_next = ST_LOAD;
         ST_LOAD: begin
            w_sub_start = 1'b1;
            w_next      = ST_MUL;
         end
         ST_MUL:     if (w_sub_done) w_next = ST_COMBINE;
         ST_COMBINE: w_next = ST_SIGN;
         ST_SIGN:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Operand capture, recombination register and result/flag outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_amag     <= '0;
         r_bmag     <= '0;
         r_neg      <= 1'b0;
         r_signed   <= 1'b0;
         r_mag      <= '0;
         r_product  <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_amag   <= w_a_mag;
                  r_bmag   <= w_b_mag;
                  r_neg    <= i_signed_mode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                  r_signed <= i_signed_mode;
               end
            end
            ST_COMBINE: r_mag <= w_mag;
            ST_SIGN: begin
               r_product  <= w_prod;
               r_overflow <= w_ovf;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_done     = r_done;
   assign o_product  = r_product;
   assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_karatsuba_mul_seq
//  Description : Scoreboard bench for karatsuba_mul_seq at WIDTH=16 and
//                WIDTH=8 with directed, hand-computed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_karatsuba_mul_seq;
   import karatsuba_pkg::*;

   localparam int L16 = mul_latency(16);
   localparam int L8  = mul_latency(8);

   typedef struct {
      logic [31:0] p;
      logic        ov;
      int          cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;

   logic        s16 = 1'b0, m16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, ovf16;
   logic [31:0] p16;

   logic        s8 = 1'b0, m8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, ovf8;
   logic [15:0] p8;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q16[$];
   exp_t q8[$];
   exp_t e16, e8;

   karatsuba_mul_seq #(.WIDTH(16)) u_dut16 (
      .clk           (clk),
      .reset         (reset),
      .i_start       (s16),
      .i_signed_mode (m16),
      .i_a           (a16),
      .i_b           (b16),
      .o_busy        (busy16),
      .o_done        (done16),
      .o_product     (p16),
      .o_overflow    (ovf16)
   );

   karatsuba_mul_seq #(.WIDTH(8)) u_dut8 (
      .clk           (clk),
      .reset         (reset),
      .i_start       (s8),
      .i_signed_mode (m8),
      .i_a           (a8),
      .i_b           (b8),
      .o_busy        (busy8),
      .o_done        (done8),
      .o_product     (p8),
      .o_overflow    (ovf8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge; the following posedge samples start
   task automatic issue16(input logic mode, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] ep, input logic eo, input logic push);
      exp_t e;
      s16 = 1'b1; m16 = mode; a16 = a; b16 = b;
      if (push) begin
         e.p = ep; e.ov = eo; e.cyc = cyc + 1 + L16;
         q16.push_back(e);
      end
      @(negedge clk);
      s16 = 1'b0; m16 = ~mode; a16 = ~a; b16 = b ^ 16'h5A5A;
   endtask

   task automatic issue8(input logic mode, input logic [7:0] a, input logic [7:0] b,
                         input logic [31:0] ep, input logic eo);
      exp_t e;
      s8 = 1'b1; m8 = mode; a8 = a; b8 = b;
      e.p = ep; e.ov = eo; e.cyc = cyc + 1 + L8;
      q8.push_back(e);
      @(negedge clk);
      s8 = 1'b0; m8 = ~mode; a8 = ~a; b8 = b ^ 8'h5A;
   endtask

   task automatic wait_done16(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done16 && n < 40);
      chk({name, " done seen"}, {31'd0, done16}, 32'd1);
   endtask

   task automatic wait_done8(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done8 && n < 40);
      chk({name, " done seen"}, {31'd0, done8}, 32'd1);
   endtask

   // Monitor for the 16-bit instance
   initial forever begin
      @(negedge clk);
      if (!reset && done16) begin
         if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w16 unexpected done: product 0x%0h, expected no done (cycle %0d)", p16, cyc);
         end else begin
            e16 = q16.pop_front();
            chk("w16 product",  p16, e16.p);
            chk("w16 overflow", {31'd0, ovf16}, {31'd0, e16.ov});
            chk("w16 latency",  cyc, e16.cyc);
         end
      end
   end

   // Monitor for the 8-bit instance
   initial forever begin
      @(negedge clk);
      if (!reset && done8) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w8 unexpected done: product 0x%0h, expected no done (cycle %0d)", p8, cyc);
         end else begin
            e8 = q8.pop_front();
            chk("w8 product",  {16'd0, p8}, e8.p);
            chk("w8 overflow", {31'd0, ovf8}, {31'd0, e8.ov});
            chk("w8 latency",  cyc, e8.cyc);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset product",  p16, 32'd0);
      chk("reset overflow", {31'd0, ovf16}, 32'd0);
      chk("reset busy",     {31'd0, busy16}, 32'd0);
      chk("reset done",     {31'd0, done16}, 32'd0);
      chk("reset product8", {16'd0, p8}, 32'd0);

      // 3*5 signed with full busy profile
      issue16(1'b1, 16'd3, 16'd5, 32'h0000000F, 1'b0, 1'b1);
      for (int k = 1; k <= L16; k++) begin
         @(negedge clk);
         chk($sformatf("busy cycle %0d", k), {31'd0, busy16}, (k == L16) ? 32'd0 : 32'd1);
      end

      // Back-to-back issue in the done cycle
      issue16(1'b0, 16'd4, 16'd4, 32'd16, 1'b0, 1'b1);
      wait_done16("4x4");
      issue16(1'b1, 16'hFFF9, 16'd300, 32'hFFFFF7CC, 1'b0, 1'b1);
      wait_done16("-7x300");
      issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b1);
      wait_done16("min x min");
      issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 1'b1);
      wait_done16("ffff sq");
      issue16(1'b0, 16'h1234, 16'h5678, 32'h06260060, 1'b1, 1'b1);
      wait_done16("1234x5678");

      // Start while busy is ignored
      issue16(1'b1, 16'd2, 16'd3, 32'd6, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      s16 = 1'b1; a16 = 16'd9; b16 = 16'd3;
      @(negedge clk);
      s16 = 1'b0;
      wait_done16("2x3 with extra start");
      repeat (L16 + 4) @(negedge clk);
      chk("idle after ignored start", {31'd0, busy16}, 32'd0);

      // Reset in the middle of an operation
      issue16(1'b1, 16'd5, 16'd6, 32'd0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort product",  p16, 32'd0);
      chk("abort overflow", {31'd0, ovf16}, 32'd0);
      chk("abort busy",     {31'd0, busy16}, 32'd0);
      chk("abort done",     {31'd0, done16}, 32'd0);
      reset = 1'b0;
      repeat (L16 + 8) @(negedge clk);
      issue16(1'b1, 16'd3, 16'd5, 32'h0000000F, 1'b0, 1'b1);
      wait_done16("after abort");

      // 8-bit instance
      issue8(1'b1, 8'h7F, 8'h80, 32'h0000C080, 1'b1);
      wait_done8("127x-128");
      issue8(1'b0, 8'hFF, 8'hFF, 32'h0000FE01, 1'b1);
      wait_done8("ff sq");
      issue8(1'b1, 8'hFF, 8'hFF, 32'h00000001, 1'b0);
      wait_done8("-1x-1");
      issue8(1'b1, 8'hFD, 8'h05, 32'h0000FFF1, 1'b0);
      wait_done8("-3x5");

      repeat (5) @(negedge clk);
      chk("w16 queue drained", q16.size(), 32'd0);
      chk("w8 queue drained",  q8.size(),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
